// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and parameter defaults.
package fetch_unit_pkg;

  localparam int          DEF_WORD_SIZE = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0040;
  localparam int          DEF_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buf.sv
// Instruction buffer FIFO holding {pc, word} pairs; flush wins over push and pop.
module fetch_unit_buf #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && !pop_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch into a small buffer,
// with redirect handling that squashes responses still in flight.
//
// state  | meaning
// BOOT   | one idle cycle after reset release, nothing issued
// RUN    | fetching sequentially while credit is available
// SQUASH | waiting for stale responses from before a redirect, dropping each
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int                   WORD_SIZE = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(DEF_RESET_PC),
  parameter int                   BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic [WORD_SIZE-1:0] inst_pcplus4
);

  localparam int          CW     = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] CREDIT = (CW + 1)'(BUF_DEPTH);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        discard_q, discard_d;
  logic [CW-1:0]        outst_after_resp;
  logic [CW-1:0]        buf_count;
  logic [WORD_SIZE-1:0] redir_pc;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 unused_redir_lsb;

  assign redir_pc         = {redirect_pc[WORD_SIZE-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign outst_after_resp = outst_q - CW'(imem_rvalid);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    imem_req   = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    if (redirect_valid) begin
      // A response arriving alongside the redirect is already stale and is dropped here.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      outst_d    = outst_after_resp;
      discard_d  = outst_after_resp;
      state_d    = (outst_after_resp != '0) ? ST_SQUASH : ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          imem_req = (({1'b0, outst_q} + {1'b0, buf_count}) < CREDIT);
          issue    = imem_req & imem_ack;
          if (imem_rvalid) begin
            push      = 1'b1;
            resp_pc_d = resp_pc_q + WORD_SIZE'(4);
          end
          if (issue) fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
          outst_d = outst_after_resp + CW'(issue);
        end
        ST_SQUASH: begin
          if (imem_rvalid) begin
            discard_d = discard_q - CW'(1);
            outst_d   = outst_after_resp;
          end
          if (discard_d == '0) state_d = ST_RUN;
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (buf_count != '0);
  assign pop        = inst_valid & inst_ready & ~redirect_valid;

  fetch_unit_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * WORD_SIZE)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({resp_pc_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      ({inst_pc, inst}),
    .count_o     (buf_count)
  );

  assign inst_pcplus4 = inst_pc + WORD_SIZE'(4);

  a_resp_expected: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a program-flow reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_pops = 0;
  int          ack_mode = 1;   // 1: always ack, 0: random
  int          rdy_mode = 1;   // 1: always ready, 2: never, 0: random
  int          lat_max = 1;
  pend_t       pend[$];
  logic [31:0] exp_q[$];       // next expected instruction address in program order
  logic [31:0] iss_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting, got no event expected one (t=%0t)", name, $time);
  endtask

  // Environment: ack/ready policy and in-order memory responses.
  always @(posedge clk) begin
    #1;
    cyc++;
    imem_ack = (ack_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    case (rdy_mode)
      1:       inst_ready = 1'b1;
      2:       inst_ready = 1'b0;
      default: inst_ready = 1'($urandom_range(0, 1));
    endcase
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  always @(negedge clk) begin : mem_model
    if (imem_rvalid && pend.size() > 0) pend.delete(0);
    if (imem_req && imem_ack) begin
      pend_t p;
      p.addr = imem_addr;
      p.due  = cyc + 1 + int'($urandom_range(0, lat_max - 1));
      pend.push_back(p);
      iss_log.push_back(imem_addr);
    end
    if (!reset_n) begin
      pend.delete();
      iss_log.delete();
    end
  end

  // Scoreboard monitor: every instruction popped must be the next in program order.
  always @(negedge clk) begin : monitor
    logic [31:0] pc;
    if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: got inst_pc %h expected no instruction", inst_pc);
      end else begin
        pc = exp_q.pop_front();
        check("inst_pc", inst_pc, pc);
        check("inst", inst, memf(pc));
        check("inst_pcplus4", inst_pcplus4, pc + 32'd4);
        exp_q.push_back(pc + 32'd4);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_pcplus4", inst_pcplus4, 32'd4);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RPC);
    @(negedge clk);
    check("boot_no_req", 32'(imem_req), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    exp_q.push_back({tgt[31:2], 2'b00});
    iss_log.delete();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (iss_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (iss_log.size() < n) timeout(name);
  endtask

  initial begin
    logic [31:0] tgt;

    // First fetches after reset
    ack_mode = 1; rdy_mode = 1; lat_max = 1;
    apply_reset();
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RPC);
    wait_issues(3, 20, "first3");
    if (iss_log.size() >= 3) begin
      check("iss0", iss_log[0], 32'h40);
      check("iss1", iss_log[1], 32'h44);
      check("iss2", iss_log[2], 32'h48);
    end
    repeat (10) @(negedge clk);

    // Decoder stall: credit limits to buffer depth
    rdy_mode = 2;
    apply_reset();
    repeat (10) @(negedge clk);
    check("stall_issued", 32'(iss_log.size()), 32'd2);
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    check("stall_head", inst_pc, 32'h40);
    rdy_mode = 1;
    repeat (10) @(negedge clk);

    // Redirect with two requests in flight
    rdy_mode = 2; lat_max = 4;
    apply_reset();
    wait_issues(2, 10, "two_out");
    do_redirect(32'h0000_1003);
    rdy_mode = 1;
    wait_issues(1, 30, "after_redir");
    if (iss_log.size() >= 1) check("redir_addr", iss_log[0], 32'h1000);
    repeat (12) @(negedge clk);

    // Address wrap
    lat_max = 1;
    do_redirect(32'hFFFF_FFFC);
    wait_issues(2, 20, "wrap");
    if (iss_log.size() >= 2) begin
      check("wrap0", iss_log[0], 32'hFFFF_FFFC);
      check("wrap1", iss_log[1], 32'h0000_0000);
    end
    repeat (10) @(negedge clk);

    // Reset while squashing
    rdy_mode = 2; lat_max = 6;
    apply_reset();
    wait_issues(2, 10, "sq_two_out");
    do_redirect(32'h0000_0800);
    apply_reset();
    rdy_mode = 1;
    wait_issues(1, 20, "restart");
    if (iss_log.size() >= 1) check("restart_addr", iss_log[0], RPC);
    repeat (10) @(negedge clk);

    // Randomized traffic with random redirects and one mid-run reset
    ack_mode = 0; rdy_mode = 0; lat_max = 3;
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      @(posedge clk); #1;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: tgt = 32'($urandom_range(0, 255));
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("progress", 32'(n_pops > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
